// File: rtl/teclado_cajero_if.sv
// Keypad-to-controller bundle: raw key strobes in, PIN digits / committed amount out.
// The slave modport is the keypad front-end; the master side is scanner plus ATM controller.
interface teclado_cajero_if #(
   parameter int ANCHO_MONTO = 32
);
   logic                   TECLA_STB;
   logic [4:0]             TECLA;
   logic                   MODO_MONTO;
   logic [3:0]             DIGITO;
   logic                   DIGITO_STB;
   logic [ANCHO_MONTO-1:0] MONTO;
   logic                   MONTO_STB;
   logic                   CANCELAR;
   logic                   DESBORDE;

   modport master (
      output TECLA_STB, TECLA, MODO_MONTO,
      input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, CANCELAR, DESBORDE
   );

   modport slave (
      input  TECLA_STB, TECLA, MODO_MONTO,
      output DIGITO, DIGITO_STB, MONTO, MONTO_STB, CANCELAR, DESBORDE
   );
endinterface

// File: rtl/teclado_cajero.sv
// ATM keypad front-end: forwards PIN nibbles, accumulates decimal amounts up to ENTER.
// Optional inactivity cancel of partial amounts is built when TECLADO_TIMEOUT_EN is defined.
//
// state  | meaning
// PIN    | PIN entry, data nibbles forwarded on DIGITO
// ACUM   | amount entry, decimal digits accumulated into acc
// LISTO  | amount committed, MONTO/MONTO_STB held until cancel or mode drop
module teclado_cajero #(
   parameter int MAX_DIGITOS    = 8,
   parameter int ANCHO_MONTO    = 32,
   parameter int TIMEOUT_CICLOS = 1000
) (
   input logic              clk,
   input logic              reset,
   teclado_cajero_if.slave  bus
);
   localparam int ANCHO_CNT = $clog2(MAX_DIGITOS + 1);
   localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(MAX_DIGITOS);

   localparam logic [1:0] ST_PIN   = 2'd0;
   localparam logic [1:0] ST_ACUM  = 2'd1;
   localparam logic [1:0] ST_LISTO = 2'd2;

   if (TIMEOUT_CICLOS < 1 || ANCHO_MONTO < 4 || MAX_DIGITOS < 1) begin : g_param_chk
      $error("teclado_cajero: illegal parameter set");
   end

   logic [1:0]             r_estado;
   logic [ANCHO_MONTO-1:0] r_acc;
   logic [ANCHO_CNT-1:0]   r_cnt;
   logic [3:0]             r_digito;
   logic                   r_digito_stb;
   logic [ANCHO_MONTO-1:0] r_monto;
   logic                   r_monto_stb;
   logic                   r_cancelar;
   logic                   r_desborde;

   logic [3:0]             w_nibble;
   logic                   w_dato;
   logic                   w_enter;
   logic                   w_borrar;
   logic                   w_cancel;
   logic                   w_decimal;
   logic                   w_cambio_modo;
   logic                   w_timeout;
   logic [ANCHO_MONTO-1:0] w_acc_sig;

   assign w_nibble  = bus.TECLA[3:0];
   assign w_dato    = bus.TECLA_STB && !bus.TECLA[4];
   assign w_enter   = bus.TECLA_STB &&  bus.TECLA[4] && (bus.TECLA[1:0] == 2'b00);
   assign w_borrar  = bus.TECLA_STB &&  bus.TECLA[4] && (bus.TECLA[1:0] == 2'b01);
   assign w_cancel  = bus.TECLA_STB &&  bus.TECLA[4] && (bus.TECLA[1:0] == 2'b10);
   assign w_decimal = (w_nibble <= 4'd9);

   // acc*10 as shift-add; wraps silently if MAX_DIGITOS is oversized for ANCHO_MONTO
   assign w_acc_sig = (r_acc << 3) + (r_acc << 1) + ANCHO_MONTO'(w_nibble);

   // Mode change has priority over any key presented in the same cycle
   assign w_cambio_modo = (r_estado == ST_PIN) ? bus.MODO_MONTO : !bus.MODO_MONTO;

`ifdef TECLADO_TIMEOUT_EN
   localparam int ANCHO_TMR = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [ANCHO_TMR-1:0] TMR_RECARGA = ANCHO_TMR'(TIMEOUT_CICLOS - 1);

   logic [ANCHO_TMR-1:0] r_tmr;
   logic                 w_tmr_activo;

   assign w_tmr_activo = (r_estado == ST_ACUM) && (r_cnt != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmr <= TMR_RECARGA;
      end else if (bus.TECLA_STB) begin
         r_tmr <= TMR_RECARGA;
      end else if (w_tmr_activo && (r_tmr != '0)) begin
         r_tmr <= r_tmr - 1'b1;
      end
   end

   // Reload-to-(N-1) makes the cancel land exactly N cycles after the last key
   assign w_timeout = w_tmr_activo && (r_tmr == '0) && !bus.TECLA_STB;
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado     <= ST_PIN;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_digito     <= 4'd0;
         r_digito_stb <= 1'b0;
         r_monto      <= '0;
         r_monto_stb  <= 1'b0;
         r_cancelar   <= 1'b0;
         r_desborde   <= 1'b0;
      end else begin
         r_digito_stb <= 1'b0;
         r_cancelar   <= 1'b0;
         if (w_cambio_modo) begin
            if (r_estado == ST_PIN) begin
               r_estado <= ST_ACUM;
            end else begin
               r_estado    <= ST_PIN;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_monto     <= '0;
               r_monto_stb <= 1'b0;
               r_desborde  <= 1'b0;
            end
         end else begin
            case (r_estado)
               ST_PIN: begin
                  if (w_dato) begin
                     r_digito     <= w_nibble;
                     r_digito_stb <= 1'b1;
                  end
                  if (w_cancel) begin
                     r_cancelar <= 1'b1;
                  end
               end
               ST_ACUM: begin
                  if (w_dato) begin
                     if (w_decimal) begin
                        if (r_cnt < CNT_MAX) begin
                           r_acc <= w_acc_sig;
                           r_cnt <= r_cnt + 1'b1;
                        end else begin
                           r_desborde <= 1'b1;
                        end
                     end
                  end else if (w_borrar) begin
                     r_acc      <= '0;
                     r_cnt      <= '0;
                     r_desborde <= 1'b0;
                  end else if (w_enter) begin
                     if (r_cnt != '0) begin
                        r_monto     <= r_acc;
                        r_monto_stb <= 1'b1;
                        r_estado    <= ST_LISTO;
                     end
                  end else if (w_cancel || w_timeout) begin
                     r_acc      <= '0;
                     r_cnt      <= '0;
                     r_cancelar <= 1'b1;
                  end
               end
               ST_LISTO: begin
                  if (w_cancel) begin
                     r_monto     <= '0;
                     r_monto_stb <= 1'b0;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_cancelar  <= 1'b1;
                     r_estado    <= ST_ACUM;
                  end
               end
               default: begin
                  r_estado <= ST_PIN;
               end
            endcase
         end
      end
   end

   assign bus.DIGITO     = r_digito;
   assign bus.DIGITO_STB = r_digito_stb;
   assign bus.MONTO      = r_monto;
   assign bus.MONTO_STB  = r_monto_stb;
   assign bus.CANCELAR   = r_cancelar;
   assign bus.DESBORDE   = r_desborde;

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed bench for teclado_cajero: PIN forwarding, amount accumulation, overflow, cancel, reset.
module tb_teclado_cajero;
   localparam logic [4:0] K_ENTER  = 5'h10;
   localparam logic [4:0] K_BORRAR = 5'h11;
   localparam logic [4:0] K_CANCEL = 5'h12;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   teclado_cajero_if #(.ANCHO_MONTO(32)) bus ();

   teclado_cajero #(
      .MAX_DIGITOS   (8),
      .ANCHO_MONTO   (32),
      .TIMEOUT_CICLOS(20)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [4:0] code);
      bus.TECLA     = code;
      bus.TECLA_STB = 1'b1;
      tick();
      bus.TECLA_STB = 1'b0;
   endtask

   logic [3:0] pin_keys [4];
   int         espera;
   logic       visto;

   initial begin
      total = 0;
      bad   = 0;
      pin_keys[0] = 4'hE; pin_keys[1] = 4'h3; pin_keys[2] = 4'h6; pin_keys[3] = 4'h8;
      bus.TECLA_STB  = 1'b0;
      bus.TECLA      = 5'h00;
      bus.MODO_MONTO = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      chk("rst_digito_stb", 32'(bus.DIGITO_STB), 32'd0);
      chk("rst_digito",     32'(bus.DIGITO),     32'd0);
      chk("rst_monto",      bus.MONTO,           32'd0);
      chk("rst_monto_stb",  32'(bus.MONTO_STB),  32'd0);
      chk("rst_cancelar",   32'(bus.CANCELAR),   32'd0);
      chk("rst_desborde",   32'(bus.DESBORDE),   32'd0);
      reset = 1'b1;
      tick();
      key(K_ENTER);
      chk("pin_enter_stb", 32'(bus.DIGITO_STB), 32'd0);
      chk("pin_enter_mst", 32'(bus.MONTO_STB),  32'd0);

      // PIN nibbles spaced 3 cycles apart
      for (int i = 0; i < 4; i++) begin
         key({1'b0, pin_keys[i]});
         chk("pin_stb_hi", 32'(bus.DIGITO_STB), 32'd1);
         chk("pin_digito", 32'(bus.DIGITO),     32'(pin_keys[i]));
         tick();
         chk("pin_stb_lo", 32'(bus.DIGITO_STB), 32'd0);
         tick();
      end
      key(K_CANCEL);
      chk("pin_cancel_hi", 32'(bus.CANCELAR), 32'd1);
      tick();
      chk("pin_cancel_lo", 32'(bus.CANCELAR), 32'd0);

      // 1, 5, ENTER -> 15
      bus.MODO_MONTO = 1'b1;
      tick();
      key(5'h01);
      key(5'h05);
      key(K_ENTER);
      chk("m15_monto", bus.MONTO,          32'h0000000F);
      chk("m15_stb",   32'(bus.MONTO_STB), 32'd1);
      key(5'h09);
      chk("m15_hold",  bus.MONTO,          32'h0000000F);
      chk("m15_hstb",  32'(bus.MONTO_STB), 32'd1);
      bus.MODO_MONTO = 1'b0;
      tick();
      chk("m15_drop_stb", 32'(bus.MONTO_STB), 32'd0);
      chk("m15_drop_mon", bus.MONTO,          32'd0);

      // Nine '1' keys back to back: ninth is dropped
      bus.MODO_MONTO = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) key(5'h01);
      chk("ovf_before", 32'(bus.DESBORDE), 32'd0);
      key(5'h01);
      chk("ovf_after",  32'(bus.DESBORDE), 32'd1);
      key(K_ENTER);
      chk("ovf_monto",  bus.MONTO,          32'd11111111);
      chk("ovf_stb",    32'(bus.MONTO_STB), 32'd1);
      bus.MODO_MONTO = 1'b0;
      tick();
      chk("ovf_clear",  32'(bus.DESBORDE), 32'd0);

      // 4, 2, BORRAR, 0xC, 7, ENTER -> 7
      bus.MODO_MONTO = 1'b1;
      tick();
      key(5'h04);
      key(5'h02);
      key(K_BORRAR);
      key(5'h0C);
      key(5'h07);
      key(K_ENTER);
      chk("b7_monto",    bus.MONTO,          32'd7);
      chk("b7_desborde", 32'(bus.DESBORDE),  32'd0);
      chk("b7_stb",      32'(bus.MONTO_STB), 32'd1);
      key(K_CANCEL);
      chk("b7_cancel_hi", 32'(bus.CANCELAR),  32'd1);
      chk("b7_cancel_st", 32'(bus.MONTO_STB), 32'd0);
      chk("b7_cancel_mo", bus.MONTO,          32'd0);
      tick();
      chk("b7_cancel_lo", 32'(bus.CANCELAR),  32'd0);
      key(K_ENTER);
      chk("empty_enter",  32'(bus.MONTO_STB), 32'd0);

      // Key in the same cycle as a mode drop is discarded
      bus.MODO_MONTO = 1'b0;
      key(5'h05);
      chk("race_drop",  32'(bus.DIGITO_STB), 32'd0);
      key(5'h05);
      chk("race_next",  32'(bus.DIGITO_STB), 32'd1);
      chk("race_dig",   32'(bus.DIGITO),     32'd5);

      // Reset mid-entry must wipe the partial accumulator
      bus.MODO_MONTO = 1'b1;
      tick();
      key(5'h03);
      key(5'h04);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_dig", 32'(bus.DIGITO), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      key(5'h09);
      key(K_ENTER);
      chk("mid_rst_monto", bus.MONTO, 32'd9);

      key(K_CANCEL);
      chk("to_pre_cancel", 32'(bus.CANCELAR), 32'd1);
      tick();
      key(5'h03);
      espera = 0;
      visto  = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      while (!visto && espera < 40) begin
         tick();
         espera++;
         visto = bus.CANCELAR;
      end
      chk("to_fired", 32'(visto),  32'd1);
      chk("to_delay", 32'(espera), 32'd20);
      tick();
      key(K_ENTER);
      chk("to_enter_ign", 32'(bus.MONTO_STB), 32'd0);
`else
      while (espera < 40) begin
         tick();
         espera++;
         if (bus.CANCELAR) visto = 1'b1;
      end
      chk("noto_quiet", 32'(visto), 32'd0);
      key(K_ENTER);
      chk("noto_held",  bus.MONTO,  32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
